// File: rtl/scratchpad_seq.sv
// ---------------------------------------------------------------------------
// scratchpad_seq
//
// Sequencer for the scrypt scratchpad RAM (256-bit words, registered read
// address, 2^ADDRBITS entries). One job runs two phases:
//   FILL   : streams 2^ADDRBITS words from the hash core into consecutive
//            addresses starting at 0.
//   LOOKUP : serves 2^ADDRBITS data-dependent read requests. Each response
//            comes back one cycle after its request is accepted.
//
// Ports
//   clk, reset      clock and asynchronous active-high reset
//   start           begin a job (sampled in IDLE only)
//   abort           synchronous cancel from any state
//   wr_valid/wr_data/wr_ready                 fill stream handshake
//   rd_req_valid/rd_req_index/rd_req_ready    lookup request handshake
//   rd_resp_valid/rd_resp_data                lookup response (no backpressure)
//   busy            state is not IDLE
//   done            one-cycle pulse alongside the final lookup response
//   ram_waddr/ram_data/ram_wren/ram_raddr/ram_q   attached RAM port
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no job; waits for start
// FILL   | accepting fill words, fill_cnt is the next write address
// LOOKUP | accepting read requests, look_cnt counts accepted requests
// ---------------------------------------------------------------------------
module scratchpad_seq #(
  parameter int ADDRBITS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                wr_valid,
  input  logic [255:0]        wr_data,
  output logic                wr_ready,
  input  logic                rd_req_valid,
  input  logic [ADDRBITS-1:0] rd_req_index,
  output logic                rd_req_ready,
  output logic                rd_resp_valid,
  output logic [255:0]        rd_resp_data,
  output logic                busy,
  output logic                done,
  output logic [ADDRBITS-1:0] ram_waddr,
  output logic [255:0]        ram_data,
  output logic                ram_wren,
  output logic [ADDRBITS-1:0] ram_raddr,
  input  logic [255:0]        ram_q
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    LOOKUP = 2'd2
  } state_t;

  localparam logic [ADDRBITS-1:0] CNT_ONE  = {{(ADDRBITS-1){1'b0}}, 1'b1};
  localparam logic [ADDRBITS-1:0] CNT_ZERO = '0;

  state_t              state;
  logic [ADDRBITS-1:0] fill_cnt;
  logic [ADDRBITS-1:0] look_cnt;
  logic                resp_pend;
  logic                done_pend;

  logic                wr_fire;
  logic                rd_fire;
  logic                fill_last;
  logic                look_last;

  // Readies depend on abort combinationally so that abort wins over any
  // handshake offered in the same cycle.
  assign wr_ready     = (state == FILL)   && !abort;
  assign rd_req_ready = (state == LOOKUP) && !abort;

  assign wr_fire   = wr_valid     && wr_ready;
  assign rd_fire   = rd_req_valid && rd_req_ready;
  assign fill_last = &fill_cnt;
  assign look_last = &look_cnt;

  // RAM port: write side is only ever enabled by a fill handshake; the read
  // address follows the request index in every state since the RAM registers
  // it and the response is simply ram_q one cycle later.
  assign ram_wren  = wr_fire;
  assign ram_waddr = fill_cnt;
  assign ram_data  = wr_data;
  assign ram_raddr = rd_req_index;

  assign rd_resp_valid = resp_pend;
  assign rd_resp_data  = ram_q;
  assign done          = done_pend;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fill_cnt  <= CNT_ZERO;
      look_cnt  <= CNT_ZERO;
      resp_pend <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      // rd_fire is already low under abort, which clears both flags.
      resp_pend <= rd_fire;
      done_pend <= rd_fire && look_last;

      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= FILL;
              fill_cnt <= CNT_ZERO;
            end
          end

          FILL: begin
            if (wr_fire) begin
              fill_cnt <= fill_cnt + CNT_ONE;
              if (fill_last) begin
                state    <= LOOKUP;
                look_cnt <= CNT_ZERO;
              end
            end
          end

          LOOKUP: begin
            if (rd_fire) begin
              look_cnt <= look_cnt + CNT_ONE;
              if (look_last) begin
                state <= IDLE;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/scratchpad_seq.md
# scratchpad_seq

Sequencer that owns the write and read ports of the scrypt scratchpad `ram` (256-bit words, registered read address, 2^ADDRBITS entries). It runs one job in two phases. FILL streams 2^ADDRBITS words from the salsa/mix core into consecutive addresses. LOOKUP serves 2^ADDRBITS data-dependent read requests and returns each word with fixed latency. It sits between the hash core and one `ram` instance.

## Interface
- ADDRBITS, 10, scratchpad address width; depth = 2^ADDRBITS; must match the attached `ram`.
- clk  in  1  single clock for this block and the attached `ram`.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- start  in  1  begin a job; sampled only in IDLE.
- abort  in  1  synchronous cancel from any state.
- wr_valid  in  1  fill word offered.
- wr_data  in  256  fill word.
- wr_ready  out  1  fill word accepted when high together with wr_valid.
- rd_req_valid  in  1  lookup request offered.
- rd_req_index  in  ADDRBITS  lookup address.
- rd_req_ready  out  1  lookup request accepted when high together with rd_req_valid.
- rd_resp_valid  out  1  lookup data valid; no backpressure.
- rd_resp_data  out  256  lookup data.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse when the last lookup response is delivered.
- ram_waddr  out  ADDRBITS  connects to `ram.waddr`.
- ram_data  out  256  connects to `ram.data`.
- ram_wren  out  1  connects to `ram.wren`.
- ram_raddr  out  ADDRBITS  connects to `ram.raddr`.
- ram_q  in  256  connects to `ram.q`.

## Operation
- States: IDLE, FILL, LOOKUP. Registers:
  - state
  - fill_cnt and look_cnt, each ADDRBITS wide
  - resp_pend, 1 bit
  - done_pend, 1 bit
- IDLE:
  - wr_ready = rd_req_ready = 0.
  - start=1 and abort=0 → FILL; fill_cnt cleared to 0.
- FILL:
  - wr_ready = !abort.
  - A write handshake drives ram_wren=1, ram_waddr=fill_cnt, ram_data=wr_data, then increments fill_cnt.
  - A handshake with fill_cnt = all-ones → LOOKUP; look_cnt cleared to 0; fill_cnt wraps to 0.
  - wr_valid low stalls the phase indefinitely.
- LOOKUP:
  - rd_req_ready = !abort.
  - ram_raddr = rd_req_index combinationally, in every state.
  - A request handshake sets resp_pend for the next cycle and increments look_cnt.
  - A handshake with look_cnt = all-ones → IDLE and sets done_pend.
- Response path:
  - rd_resp_valid = resp_pend.
  - rd_resp_data = ram_q, combinational passthrough. This is valid only while rd_resp_valid=1; ram_q follows ram_raddr every cycle.
  - done = done_pend, which coincides with the final rd_resp_valid.
- ram_wren = wr_valid & wr_ready, so it is never asserted outside FILL.
- start in FILL or LOOKUP is ignored.
- start in the done cycle (state already IDLE) is accepted. The new FILL's first write lands the cycle after the final read; there is no port conflict.
- abort:
  - Has priority over every handshake in the same cycle; both readies are forced low.
  - Next state IDLE; resp_pend and done_pend cleared. A response already pending from the previous cycle still appears in the abort cycle.
  - RAM contents are left as is.
- Counters wrap modulo 2^ADDRBITS; no overflow flag. The RAM has no reset; contents persist across jobs and resets.

## Timing
- Reset values:
  - state=IDLE; fill_cnt=look_cnt=0; resp_pend=done_pend=0.
  - Outputs: wr_ready=0, rd_req_ready=0, rd_resp_valid=0, done=0, busy=0, ram_wren=0.
- start accepted at edge t → FILL; wr_ready=1 from cycle t+1.
- Write handshake at edge t → data stored in `ram` at edge t.
- Read request handshake in cycle t (edge t+1) → rd_resp_valid=1 and correct rd_resp_data in cycle t+1. Latency is 1.
- One lookup per cycle sustained, with full throughput back-to-back.
- Minimum job length with no stalls: 1 start cycle + 2^ADDRBITS fill cycles + 2^ADDRBITS lookup cycles + 1 response cycle.
- busy falls the cycle after the last request is accepted, which is the same cycle done pulses.
- reset asserted mid-job: all registers return to reset values immediately (asynchronous); no further ram_wren.

## Test plan
- ADDRBITS=2; start; fill 4 words 0xA0..A3 back-to-back; request indices 3,0,2,1 → responses 0xA3,0xA0,0xA2,0xA1, each one cycle after its request; done high with the 0xA1 response; busy low in that cycle.
- FILL with wr_valid gaps (pattern 1,0,0,1,1,0,1) → exactly 4 writes at addresses 0..3; wr_ready held 1; LOOKUP entered only after the 4th handshake.
- ADDRBITS=10 full job with random data and random indices including 0 and 1023 → every response matches the scoreboard; exactly 1024 rd_resp_valid pulses, one done.
- abort asserted during the 2nd lookup with rd_req_valid=1 → request not accepted; the response for lookup 1 still appears in the abort cycle; then IDLE with no done.
- Async reset pulse mid-FILL (between clock edges) → outputs go to reset values before the next edge; restarting the job behaves exactly as scenario 1.
- start asserted in the done cycle → new FILL begins the next cycle; start pulses during FILL/LOOKUP are ignored, so counts are unaffected.
